// File: rtl/eth_tx_sequencer.sv
// Ethernet transmit framer: preamble/SFD, payload with zero padding up to MIN_LEN,
// FCS taken from an external CRC engine, inter-frame gap, and underrun/oversize abort.
module eth_tx_sequencer #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int IFG_LEN = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        tx_er,
  output logic        crc_rst,
  output logic        crc_en,
  output logic [7:0]  crc_data,
  input  logic [31:0] crc_in,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Handshake: an input byte transfers on a rising edge where in_valid & in_ready are
  // both high; in_ready never depends on in_valid, and in_data/in_last must hold while
  // in_valid is high and in_ready is low.

  localparam int TW = ($clog2(IFG_LEN + 1) > 3) ? $clog2(IFG_LEN + 1) : 3;

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN} state_t;

  state_t        state, state_nx;
  logic [10:0]   cnt, cnt_nx, cnt_inc;
  logic [TW-1:0] tmr, tmr_nx;
  logic [7:0]    tx_data_nx;
  logic          tx_en_nx, tx_er_nx;

  assign cnt_inc   = cnt + 11'd1;
  assign state_dbg = state;

  // tx_* registers are loaded from the byte chosen this cycle, so the preamble
  // starts one cycle after IDLE sees in_valid and SFD is on the wire during SFD.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    tmr_nx     = tmr;
    tx_data_nx = 8'h00;
    tx_en_nx   = 1'b0;
    tx_er_nx   = 1'b0;
    in_ready   = 1'b0;
    crc_en     = 1'b0;
    crc_data   = 8'h00;
    crc_rst    = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        crc_rst = 1'b1;
        cnt_nx  = '0;
        tmr_nx  = '0;
        if (in_valid) begin
          state_nx   = PRE;
          tx_en_nx   = 1'b1;
          tx_data_nx = 8'h55;
        end
      end

      PRE: begin
        tx_en_nx = 1'b1;
        if (tmr == TW'(6)) begin
          tx_data_nx = 8'hD5;
          tmr_nx     = '0;
          state_nx   = SFD;
        end else begin
          tx_data_nx = 8'h55;
          tmr_nx     = tmr + TW'(1);
        end
      end

      // SFD already accepts the first payload byte; it appears on tx in DATA.
      SFD, DATA: begin
        in_ready = (cnt != 11'(MAX_LEN));
        if (in_ready && in_valid) begin
          crc_en     = 1'b1;
          crc_data   = in_data;
          tx_en_nx   = 1'b1;
          tx_data_nx = in_data;
          cnt_nx     = cnt_inc;
          tmr_nx     = '0;
          if (in_last) begin
            state_nx = (cnt_inc < 11'(MIN_LEN)) ? PAD : FCS;
          end else begin
            state_nx = DATA;
          end
        end else begin
          // Underrun, or MAX_LEN bytes sent without in_last.
          tx_er_nx = 1'b1;
          state_nx = DRAIN;
        end
      end

      PAD: begin
        crc_en   = 1'b1;
        tx_en_nx = 1'b1;
        cnt_nx   = cnt_inc;
        if (cnt_inc >= 11'(MIN_LEN)) begin
          state_nx = FCS;
          tmr_nx   = '0;
        end
      end

      FCS: begin
        tx_en_nx = 1'b1;
        case (tmr[1:0])
          2'd0:    tx_data_nx = crc_in[7:0];
          2'd1:    tx_data_nx = crc_in[15:8];
          2'd2:    tx_data_nx = crc_in[23:16];
          default: tx_data_nx = crc_in[31:24];
        endcase
        if (tmr[1:0] == 2'd3) begin
          state_nx = IFG;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end

      IFG: begin
        crc_rst = 1'b1;
        if (tmr == TW'(IFG_LEN - 1)) begin
          state_nx = IDLE;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end

      DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_nx = IFG;
          tmr_nx   = '0;
        end
      end

      default: state_nx = IDLE;
    endcase

    if (rst) begin
      in_ready = 1'b0;
      crc_en   = 1'b0;
      crc_data = 8'h00;
      crc_rst  = 1'b1;
      busy     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tmr     <= '0;
      tx_data <= 8'h00;
      tx_en   <= 1'b0;
      tx_er   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tmr     <= tmr_nx;
      tx_data <= tx_data_nx;
      tx_en   <= tx_en_nx;
      tx_er   <= tx_er_nx;
    end
  end

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Bench for eth_tx_sequencer: CRC-32 engine model, frame-level reference model with an
// expected tx queue, per-cycle output compare, gap/length/residue checks.
module tb_eth_tx_sequencer;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam int IFG_LEN = 12;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        tx_en, tx_er;
  logic        crc_rst, crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_in;
  logic        busy;
  logic [2:0]  state_dbg;

  eth_tx_sequencer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .IFG_LEN(IFG_LEN)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er),
    .crc_rst(crc_rst), .crc_en(crc_en), .crc_data(crc_data), .crc_in(crc_in),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- CRC-32 helpers and engine ----------------
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc32(input byte_q_t b);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    foreach (b[i]) r = crc_upd(r, b[i]);
    return ~r;
  endfunction

  function automatic int frame_len(input int l);
    return 8 + ((l < MIN_LEN) ? MIN_LEN : l) + 4;
  endfunction

  logic [31:0] crc_st;
  always @(posedge clk) begin
    if (crc_rst) crc_st <= 32'hFFFFFFFF;
    else if (crc_en) crc_st <= crc_upd(crc_st, crc_data);
  end
  assign crc_in = crc_st ^ 32'hFFFFFFFF;

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];   // {tx_er, byte}; an abort is 9'h100
  int         len_q[$];
  byte_q_t    pay;
  byte_q_t    rx_q;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         fr_cnt = 0;
  int         gap = 1000;
  int         last_gap = 0;
  logic       prev_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the byte stream a frame in `pay` must produce on tx.
  task automatic expect_frame(input int mode, input int k);
    int          n;
    logic        ab;
    byte_q_t     f;
    logic [31:0] fcs;
    repeat (7) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    ab = 1'b1;
    if (mode == 1) n = k;
    else if (pay.size() > MAX_LEN) n = MAX_LEN;
    else begin
      n  = pay.size();
      ab = 1'b0;
    end
    for (int i = 0; i < n; i++) f.push_back(pay[i]);
    if (ab) begin
      foreach (f[i]) exp_q.push_back({1'b0, f[i]});
      exp_q.push_back(9'h100);
      len_q.push_back(8 + n);
    end else begin
      while (f.size() < MIN_LEN) f.push_back(8'h00);
      fcs = crc32(f);
      f.push_back(fcs[7:0]);
      f.push_back(fcs[15:8]);
      f.push_back(fcs[23:16]);
      f.push_back(fcs[31:24]);
      foreach (f[i]) exp_q.push_back({1'b0, f[i]});
      len_q.push_back(frame_len(n));
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      prev_en = 1'b0;
      fr_cnt  = 0;
      gap     = 1000;
      rx_q.delete();
    end else begin
      if (tx_en || tx_er) begin
        if (exp_q.size() == 0) chk("tx_extra", {22'h0, tx_er, tx_en, tx_data}, 32'h0);
        else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'({tx_er, tx_er ? {tx_en, 7'h00} : tx_data}), 32'(e));
        end
      end
      if (tx_en) begin
        if (!prev_en) begin
          chk("ifg_min", 32'(gap >= IFG_LEN), 32'd1);
          last_gap = gap;
          fr_cnt   = 0;
          rx_q.delete();
        end
        fr_cnt++;
        if (fr_cnt > 8) rx_q.push_back(tx_data);
        chk("busy_tx", 32'(busy), 32'd1);
        gap = 0;
      end else begin
        if (prev_en) begin
          if (len_q.size() == 0) chk("len_extra", fr_cnt, 0);
          else chk("frame_len", fr_cnt, len_q.pop_front());
          if (!tx_er) chk("fcs_residue", crc32(rx_q), 32'h2144DF1C);
        end
        gap++;
      end
      prev_en = tx_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_frame(input int mode, input int k);
    for (int i = 0; i < pay.size(); i++) begin
      if (mode == 1 && i == k) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      in_data  = pay[i];
      in_last  = (i == pay.size() - 1);
      in_valid = 1'b1;
      wait_accept();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic rand_pay(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit          found;
    int          len, mode, k;
    logic [31:0] fcs;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_er", 32'(tx_er), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_crc_en", 32'(crc_en), 32'd0);
    chk("rst_crc_rst", 32'(crc_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Pin the model with known CRC-32 values and frame lengths.
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    fcs = crc32(pay);
    chk("model_crc_check", fcs, 32'hCBF43926);
    pay.push_back(fcs[7:0]);
    pay.push_back(fcs[15:8]);
    pay.push_back(fcs[23:16]);
    pay.push_back(fcs[31:24]);
    chk("model_residue", crc32(pay), 32'h2144DF1C);
    chk("model_len_1", frame_len(1), 72);
    chk("model_len_60", frame_len(60), 72);
    chk("model_len_max", frame_len(MAX_LEN), 1526);

    @(posedge clk);
    #1;
    rst = 1'b0;

    // 60-byte counting frame, then a 1-byte frame padded to 60.
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    expect_frame(0, 0);
    send_frame(0, 0);
    pay.delete();
    pay.push_back(8'hAB);
    expect_frame(0, 0);
    send_frame(0, 0);

    // Underrun after 10 bytes, then back-to-back 64-byte frames.
    rand_pay(30);
    expect_frame(1, 10);
    send_frame(1, 10);
    for (int j = 0; j < 3; j++) begin
      rand_pay(64);
      expect_frame(0, 0);
      send_frame(0, 0);
    end
    chk("b2b_gap", last_gap, IFG_LEN);

    // Length boundary: exactly MAX_LEN completes, MAX_LEN+2 aborts.
    rand_pay(MAX_LEN);
    expect_frame(0, 0);
    send_frame(0, 0);
    rand_pay(MAX_LEN + 2);
    expect_frame(0, 0);
    send_frame(0, 0);

    // Reset while the second FCS byte is on the wire.
    rand_pay(20);
    expect_frame(0, 0);
    send_frame(0, 0);
    found = 1'b0;
    for (int t = 0; t < 500 && !found; t++) begin
      @(negedge clk);
      #1;
      if (tx_en && fr_cnt == 70) found = 1'b1;
    end
    chk("rst_wait_fcs2", 32'(found), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    len_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tx_en", 32'(tx_en), 32'd0);
    chk("midrst_tx_er", 32'(tx_er), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_en2", 32'(tx_en), 32'd0);
    rand_pay(45);
    expect_frame(0, 0);
    send_frame(0, 0);

    // Randomized frames, some with underruns, with random idle between.
    for (int j = 0; j < 14; j++) begin
      len  = $urandom_range(1, 140);
      mode = (len > 1 && $urandom_range(0, 4) == 0) ? 1 : 0;
      k    = (mode == 1) ? $urandom_range(1, len - 1) : 0;
      rand_pay(len);
      expect_frame(mode, k);
      send_frame(mode, k);
      idle_cycles($urandom_range(0, 4));
    end

    for (int t = 0; t < 3000; t++) begin
      if (exp_q.size() == 0 && len_q.size() == 0) break;
      @(negedge clk);
    end
    chk("exp_q_empty", exp_q.size(), 0);
    chk("len_q_empty", len_q.size(), 0);
    repeat (IFG_LEN + 4) @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_tx_en", 32'(tx_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected sequence completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
